bcd_trigger_ctrl: RTL
=====================

# bcd_trigger_ctrl

Front-end controller that sequences the four-digit BCD counter on the Basys3 board. It takes four raw pushbutton inputs and synchronizes and debounces each one. Press edges are queued per channel, and a round-robin arbiter issues at most one single-cycle pulse on the counter's 4-bit Trigger bus at a time, with a mandatory idle gap between pulses. It sits between the board buttons and the counter's Trigger input.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required before a channel's debounced level changes (min 1).
- REPEAT_DELAY, 50: hold time in cycles before auto-repeat starts (used only with BCD_AUTO_REPEAT_EN).
- REPEAT_PERIOD, 10: cycles between auto-repeat re-arms (used only with BCD_AUTO_REPEAT_EN).
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- Button  in  4  raw asynchronous pushbuttons; bit i maps to counter digit i.
- Enable  in  1  when low, no new grants; pending requests are retained.
- Trigger  out  4  one-hot single-cycle pulse, or all zero; drives the counter's Trigger input.
- Pending  out  4  registered per-channel request flags.
- Busy  out  1  high while the FSM is not IDLE.

## Operation
- Per channel: 2-flop synchronizer, then a debounce counter. The debounced level takes the synchronized value after DEBOUNCE_CYCLES consecutive equal samples that differ from the current debounced level. Any mismatching sample restarts the count.
- A rising edge of the debounced level sets Pending[i]. Falling edges are ignored.
- A new edge on a channel that is already pending merges into it, giving one trigger.
- Arbiter: round-robin pointer, reset to 0.
  - Searches Pending from the pointer upward, mod 4.
  - On a grant to channel g, the pointer becomes (g+1) mod 4.
- FSM states:
  - IDLE: if Enable and Pending≠0, grant a channel, clear its Pending bit, go to FIRE.
  - FIRE: Trigger = onehot(g) for exactly this cycle; go to GAP.
  - GAP: Trigger = 0 for one cycle; go to IDLE.
- Simultaneous set and clear on the same channel in the grant cycle: set wins, so the channel stays pending.
- Enable dropping during FIRE or GAP does not abort the sequence. It only blocks the next grant.
- Reset values: Trigger=0, Pending=0, Busy=0, state=IDLE, pointer=0, debounced levels=0, synchronizers=0, debounce and repeat counters=0.
- Reset asserted mid-FIRE: Trigger is 0 from the next cycle and no partial pulse is re-issued.

## Timing
- Idle controller, Button[i] rising and stable from cycle t: Pending[i] rises at t+DEBOUNCE_CYCLES+3 and Trigger[i] is high during cycle t+DEBOUNCE_CYCLES+4.
- Back-to-back grants: the minimum spacing between Trigger pulses is 3 cycles (FIRE, GAP, IDLE).
- Worst-case wait for a pending channel is 3 other grants, i.e. 9 cycles with Enable high.
- Busy is high in FIRE and GAP, and low in IDLE.
- All outputs are registered. There are no combinational paths from any input to any output.

## Configuration
- BCD_AUTO_REPEAT_EN defined:
  - While channel i's debounced level stays high, a per-channel counter re-sets Pending[i] first after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - The counter clears when the debounced level falls or on Reset.
- Not defined: exactly one trigger per debounced press. The repeat counters and the REPEAT_* parameters have no effect.

## Structure
- Package bcd_ctrl_pkg holds:
  - NUM_CH = 4.
  - State enum {IDLE, FIRE, GAP}.
  - Function onehot4.
  - Debounce and repeat counter width constants derived via $clog2.
- One sub-module, bcd_debounce: synchronizer, debounce counter and rising-edge output for one channel, instantiated NUM_CH times.
- Arbiter, FSM and optional repeat logic live in the top module.

## Test plan
- Reset, then DEBOUNCE_CYCLES=4 and Button=0001 held stable → Trigger=0001 for exactly one cycle at t+8; Pending, Busy and Trigger end at 0.
- Button[2] bounces (3 high, 1 low, 3 high), then holds → exactly one Trigger=0100, and no pulse before the held run completes 4 stable samples.
- Button=1111 rising together → Trigger pulses 0001, 0010, 0100, 1000 in that order, 3 cycles apart.
- Enable=0 while Button[3] is pressed → Pending=1000 and no Trigger. Raise Enable → Trigger=1000 on the following FIRE cycle.
- Assert Reset during the FIRE of channel 1 with channel 2 pending → Trigger=0, Pending=0, Busy=0 the next cycle, and no later pulses.
- With BCD_AUTO_REPEAT_EN, REPEAT_DELAY=50, REPEAT_PERIOD=10, hold Button[0] for 100 cycles → first pulse plus repeats at delay 50 and every 10 cycles after (6 pulses total). Without the macro → 1 pulse.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// bcd_ctrl_pkg: shared constants, FSM states and helpers for the BCD trigger controller
package bcd_ctrl_pkg;
  localparam int NUM_CH = 4;
  typedef enum logic [1:0] {IDLE, FIRE, GAP} state_e;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction
  localparam int DEB_W_DEF = cnt_w(4);
  localparam int REP_W_DEF = cnt_w(50);
  function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] g);
    onehot4 = '0;
    onehot4[g] = 1'b1;
  endfunction
endpackage

// File: rtl/bcd_debounce.sv
// bcd_debounce: 2-flop synchronizer, debounce counter and registered rising-edge pulse for one button
// ports: clk_i, reset_i (sync, active-high), button_i (raw async), level_o (debounced), rise_o (1-cycle pulse)
module bcd_debounce
  import bcd_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic button_i,
  output logic level_o,
  output logic rise_o
);
  localparam int W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, lvl_q, lvl_d, rise_q, hit;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    hit = (s2_q != lvl_q) && (cnt_q == LAST);
    lvl_d = hit ? s2_q : lvl_q;
    cnt_d = (s2_q == lvl_q || hit) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
      rise_q <= 1'b0;
    end else begin
      s1_q <= button_i;
      s2_q <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      rise_q <= lvl_d & ~lvl_q;
    end
  end
  assign level_o = lvl_q;
  assign rise_o = rise_q;
endmodule

// File: rtl/bcd_trigger_ctrl.sv
// bcd_trigger_ctrl: debounced pushbutton front-end issuing round-robin single-cycle trigger pulses
// ports: clk_i, reset_i (sync, active-high), button_i[3:0] (raw), enable_i (gates new grants),
//        trigger_o[3:0] (one-hot pulse), pending_o[3:0] (request flags), busy_o (FSM not IDLE)
// option: define BCD_AUTO_REPEAT_EN for hold-to-repeat (REPEAT_DELAY, then every REPEAT_PERIOD)
module bcd_trigger_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] button_i,
  input  logic              enable_i,
  output logic [NUM_CH-1:0] trigger_o,
  output logic [NUM_CH-1:0] pending_o,
  output logic              busy_o
);
  state_e state_q, state_d;
  logic [1:0] ptr_q, ptr_d, gnt;
  logic [NUM_CH-1:0] pend_q, pend_d, trig_q, trig_d, lvl, rise, rep;
  logic busy_q, found, grant;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    bcd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .button_i(button_i[i]),
      .level_o(lvl[i]),
      .rise_o(rise[i])
    );
  end
`ifdef BCD_AUTO_REPEAT_EN
  localparam int RW = cnt_w(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  logic [NUM_CH-1:0][RW-1:0] rcnt_q, rcnt_d;
  logic [NUM_CH-1:0] armed_q, armed_d;
  // rcnt counts cycles since the level rose or since the last re-arm; the first
  // re-arm waits REPEAT_DELAY, later ones REPEAT_PERIOD
  always_comb begin
    rep = '0;
    rcnt_d = '0;
    armed_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rep[i] = lvl[i] && (rcnt_q[i] == (armed_q[i] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
      rcnt_d[i] = !lvl[i] ? '0 : rep[i] ? RW'(1) : rcnt_q[i] + 1'b1;
      armed_d[i] = lvl[i] && (armed_q[i] || rep[i]);
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rcnt_q <= '0;
      armed_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      armed_q <= armed_d;
    end
  end
`else
  logic unused_rep;
  assign rep = '0;
  assign unused_rep = ^{lvl, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif
  // scan downward so the lowest offset from the pointer is the one that sticks
  always_comb begin
    gnt = ptr_q;
    found = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pend_q[ptr_q + 2'(k)]) begin
        gnt = ptr_q + 2'(k);
        found = 1'b1;
      end
    end
    grant = (state_q == IDLE) && enable_i && found;
    state_d = (state_q == IDLE) ? (grant ? FIRE : IDLE) : (state_q == FIRE) ? GAP : IDLE;
    trig_d = grant ? onehot4(gnt) : '0;
    ptr_d = grant ? gnt + 2'd1 : ptr_q;
    pend_d = (pend_q & ~trig_d) | rise | rep;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q <= '0;
      pend_q <= '0;
      trig_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      pend_q <= pend_d;
      trig_q <= trig_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign trigger_o = trig_q;
  assign pending_o = pend_q;
  assign busy_o = busy_q;
endmodule
